// File: rtl/fp_seq_ctrl_if.sv
// fp_seq_ctrl_if: instruction, register-file, load/store and status bundle for fp_seq_ctrl.
// Rev 1.0
`default_nettype none

interface fp_seq_ctrl_if;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [1:0]  Instr_Kind;
  logic [3:0]  Instr_Op;
  logic [4:0]  Instr_D;
  logic [4:0]  Instr_R;
  logic [4:0]  Instr_S;
  logic        FW_En;
  logic [4:0]  FW_Addr;
  logic [4:0]  FR_Addr;
  logic [4:0]  FS_Addr;
  logic        F_Sel;
  logic [3:0]  FP_Op;
  logic [5:0]  FP_Status;
  logic [63:0] FP_R_OUT;
  logic        Load_Valid;
  logic        Load_Ready;
  logic        Store_Valid;
  logic        Store_Ready;
  logic [63:0] Store_Data;
  logic        Done;
  logic        Err;
  logic        Busy;
  logic        Clr_Status;
  logic [5:0]  Status_Sticky;

  modport slave (
    input  Instr_Valid, Instr_Kind, Instr_Op, Instr_D, Instr_R, Instr_S,
    input  FP_Status, FP_R_OUT, Load_Valid, Store_Ready, Clr_Status,
    output Instr_Ready, FW_En, FW_Addr, FR_Addr, FS_Addr, F_Sel, FP_Op,
    output Load_Ready, Store_Valid, Store_Data, Done, Err, Busy, Status_Sticky
  );

  modport master (
    output Instr_Valid, Instr_Kind, Instr_Op, Instr_D, Instr_R, Instr_S,
    output FP_Status, FP_R_OUT, Load_Valid, Store_Ready, Clr_Status,
    input  Instr_Ready, FW_En, FW_Addr, FR_Addr, FS_Addr, F_Sel, FP_Op,
    input  Load_Ready, Store_Valid, Store_Data, Done, Err, Busy, Status_Sticky
  );
endinterface

`default_nettype wire

// File: rtl/fp_seq_ctrl.sv
// fp_seq_ctrl: single-issue FP instruction sequencer driving register file, ALU, load and store ports.
// Rev 1.0
`default_nettype none

module fp_seq_ctrl (
  input  logic          W_Clk,
  input  logic          Reset,
  fp_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ALU_EXEC   = 3'd1,
    ALU_WB     = 3'd2,
    LOAD_WAIT  = 3'd3,
    STORE_RD   = 3'd4,
    STORE_WAIT = 3'd5,
    ERR_DONE   = 3'd6
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  lat_op;
  logic [4:0]  lat_d;
  logic [4:0]  lat_r;
  logic [4:0]  lat_s;
  logic [63:0] store_data;
  logic [5:0]  sticky;

  always_ff @(posedge W_Clk) begin
    if (Reset) begin
      state      <= IDLE;
      lat_op     <= 4'd0;
      lat_d      <= 5'd0;
      lat_r      <= 5'd0;
      lat_s      <= 5'd0;
      store_data <= 64'd0;
      sticky     <= 6'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.Instr_Valid) begin
        lat_op <= bus.Instr_Op;
        lat_d  <= bus.Instr_D;
        lat_r  <= bus.Instr_R;
        lat_s  <= bus.Instr_S;
      end
      if (state == STORE_RD)
        store_data <= bus.FP_R_OUT;
      // A clear coincident with write-back keeps only this instruction's flags.
      if (bus.Clr_Status)
        sticky <= (state == ALU_WB) ? bus.FP_Status : 6'd0;
      else if (state == ALU_WB)
        sticky <= sticky | bus.FP_Status;
    end
  end

  always_comb begin
    next_state      = state;
    bus.Instr_Ready = 1'b0;
    bus.FW_En       = 1'b0;
    bus.FW_Addr     = lat_d;
    bus.FR_Addr     = lat_r;
    bus.FS_Addr     = lat_s;
    bus.FP_Op       = lat_op;
    bus.F_Sel       = 1'b0;
    bus.Load_Ready  = 1'b0;
    bus.Store_Valid = 1'b0;
    bus.Done        = 1'b0;
    bus.Err         = 1'b0;
    bus.Busy        = 1'b0;
    if (!Reset) begin
      bus.Busy = (state != IDLE);
      case (state)
        IDLE: begin
          bus.Instr_Ready = 1'b1;
          if (bus.Instr_Valid) begin
            case (bus.Instr_Kind)
              2'b00:   next_state = ALU_EXEC;
              2'b01:   next_state = LOAD_WAIT;
              2'b10:   next_state = STORE_RD;
              default: next_state = ERR_DONE;
            endcase
          end
        end
        ALU_EXEC: next_state = ALU_WB;
        ALU_WB: begin
          bus.F_Sel  = 1'b1;
          bus.FW_En  = 1'b1;
          bus.Done   = 1'b1;
          next_state = IDLE;
        end
        LOAD_WAIT: begin
          bus.Load_Ready = 1'b1;
          if (bus.Load_Valid) begin
            bus.FW_En  = 1'b1;
            bus.Done   = 1'b1;
            next_state = IDLE;
          end
        end
        STORE_RD: next_state = STORE_WAIT;
        STORE_WAIT: begin
          bus.Store_Valid = 1'b1;
          if (bus.Store_Ready) begin
            bus.Done   = 1'b1;
            next_state = IDLE;
          end
        end
        ERR_DONE: begin
          bus.Done   = 1'b1;
          bus.Err    = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign bus.Store_Data    = store_data;
  assign bus.Status_Sticky = sticky;

endmodule

`default_nettype wire

// File: tb/tb_fp_seq_ctrl.sv
// tb_fp_seq_ctrl: directed cycle checks plus a completion scoreboard for fp_seq_ctrl.
// Rev 1.0
`default_nettype none

module tb_fp_seq_ctrl;

  logic W_Clk = 1'b0;
  logic Reset;
  always #5 W_Clk = ~W_Clk;

  fp_seq_ctrl_if bus ();

  fp_seq_ctrl dut (
    .W_Clk (W_Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic        sel;
    logic        err;
    logic        st;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] PI_BITS = 64'h4009_21FB_5444_2D18;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge W_Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge W_Clk);
  endtask

  task automatic push_exp(input logic wr, input logic [4:0] addr, input logic sel,
                          input logic err, input logic st, input logic [63:0] data);
    exp_t e;
    e.wr = wr; e.addr = addr; e.sel = sel; e.err = err; e.st = st; e.data = data;
    sb_q.push_back(e);
  endtask

  // Every Done pulse must match the oldest outstanding instruction.
  always @(negedge W_Clk) begin
    if (bus.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_fw_en", bus.FW_En, e.wr);
        check_eq("sb_err", bus.Err, e.err);
        check_eq("sb_store_valid", bus.Store_Valid, e.st);
        if (e.wr) begin
          check_eq("sb_fw_addr", bus.FW_Addr, e.addr);
          check_eq("sb_f_sel", bus.F_Sel, e.sel);
        end
        if (e.st)
          check_eq("sb_store_data", bus.Store_Data, e.data);
      end
    end
  end

  task automatic run_alu(input logic [3:0] op, input logic [4:0] r, input logic [4:0] s,
                         input logic [4:0] d, input logic [5:0] st, input logic clr_wb,
                         input logic [5:0] exp_sticky);
    push_exp(1'b1, d, 1'b1, 1'b0, 1'b0, 64'd0);
    bus.Instr_Valid = 1'b1;
    bus.Instr_Kind  = 2'b00;
    bus.Instr_Op    = op;
    bus.Instr_R     = r;
    bus.Instr_S     = s;
    bus.Instr_D     = d;
    bus.FP_Status   = st;
    settle();
    check_eq("alu_accept_ready", bus.Instr_Ready, 1'b1);
    tick();
    bus.Instr_Valid = 1'b0;
    bus.Instr_Op    = ~op;
    bus.Instr_R     = ~r;
    bus.Instr_S     = ~s;
    bus.Instr_D     = ~d;
    settle();
    check_eq("alu_exec_fw_en", bus.FW_En, 1'b0);
    check_eq("alu_exec_fr", bus.FR_Addr, r);
    check_eq("alu_exec_fs", bus.FS_Addr, s);
    check_eq("alu_exec_op", bus.FP_Op, op);
    check_eq("alu_exec_busy", bus.Busy, 1'b1);
    check_eq("alu_exec_ready", bus.Instr_Ready, 1'b0);
    tick();
    bus.Clr_Status = clr_wb;
    settle();
    check_eq("alu_wb_fw_en", bus.FW_En, 1'b1);
    check_eq("alu_wb_f_sel", bus.F_Sel, 1'b1);
    check_eq("alu_wb_fw_addr", bus.FW_Addr, d);
    check_eq("alu_wb_fr", bus.FR_Addr, r);
    check_eq("alu_wb_done", bus.Done, 1'b1);
    tick();
    bus.Clr_Status = 1'b0;
    settle();
    check_eq("alu_sticky", bus.Status_Sticky, exp_sticky);
    check_eq("alu_post_done", bus.Done, 1'b0);
    check_eq("alu_post_ready", bus.Instr_Ready, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset           = 1'b1;
    bus.Instr_Valid = 1'b0;
    bus.Instr_Kind  = 2'b00;
    bus.Instr_Op    = 4'd0;
    bus.Instr_D     = 5'd0;
    bus.Instr_R     = 5'd0;
    bus.Instr_S     = 5'd0;
    bus.FP_Status   = 6'd0;
    bus.FP_R_OUT    = 64'd0;
    bus.Load_Valid  = 1'b0;
    bus.Store_Ready = 1'b0;
    bus.Clr_Status  = 1'b0;
    tick();
    tick();
    bus.Instr_Valid = 1'b1;
    settle();
    check_eq("rst_instr_ready", bus.Instr_Ready, 1'b0);
    check_eq("rst_busy", bus.Busy, 1'b0);
    check_eq("rst_done", bus.Done, 1'b0);
    check_eq("rst_fw_en", bus.FW_En, 1'b0);
    check_eq("rst_sticky", bus.Status_Sticky, 6'd0);
    check_eq("rst_store_data", bus.Store_Data, 64'd0);
    check_eq("rst_fw_addr", bus.FW_Addr, 5'd0);
    tick();
    Reset           = 1'b0;
    bus.Instr_Valid = 1'b0;
    settle();
    check_eq("idle_ready", bus.Instr_Ready, 1'b1);
    check_eq("idle_busy", bus.Busy, 1'b0);
    tick();

    // ALU: Op=3, R=1, S=2, D=4, status bit 2
    run_alu(4'd3, 5'd1, 5'd2, 5'd4, 6'b000100, 1'b0, 6'b000100);

    // Load to D=7 with three idle wait cycles
    push_exp(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 64'd0);
    bus.Instr_Valid = 1'b1;
    bus.Instr_Kind  = 2'b01;
    bus.Instr_D     = 5'd7;
    tick();
    bus.Instr_Valid = 1'b0;
    bus.Instr_D     = 5'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("ld_wait_ready", bus.Load_Ready, 1'b1);
      check_eq("ld_wait_fw_en", bus.FW_En, 1'b0);
      check_eq("ld_wait_done", bus.Done, 1'b0);
      tick();
    end
    bus.Load_Valid = 1'b1;
    settle();
    check_eq("ld_ready", bus.Load_Ready, 1'b1);
    check_eq("ld_fw_en", bus.FW_En, 1'b1);
    check_eq("ld_f_sel", bus.F_Sel, 1'b0);
    check_eq("ld_fw_addr", bus.FW_Addr, 5'd7);
    check_eq("ld_done", bus.Done, 1'b1);
    tick();
    settle();
    check_eq("ld_post_ready", bus.Load_Ready, 1'b0);
    check_eq("ld_post_fw_en", bus.FW_En, 1'b0);
    check_eq("ld_post_instr_ready", bus.Instr_Ready, 1'b1);
    bus.Load_Valid = 1'b0;
    tick();

    // Store from R=5 with two cycles of backpressure
    push_exp(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, PI_BITS);
    bus.Instr_Valid = 1'b1;
    bus.Instr_Kind  = 2'b10;
    bus.Instr_R     = 5'd5;
    bus.FP_R_OUT    = PI_BITS;
    tick();
    bus.Instr_Valid = 1'b0;
    settle();
    check_eq("st_rd_fr", bus.FR_Addr, 5'd5);
    check_eq("st_rd_valid", bus.Store_Valid, 1'b0);
    tick();
    bus.FP_R_OUT = 64'hDEAD_BEEF_0000_1111;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("st_wait_valid", bus.Store_Valid, 1'b1);
      check_eq("st_wait_data", bus.Store_Data, PI_BITS);
      check_eq("st_wait_done", bus.Done, 1'b0);
      tick();
    end
    bus.Store_Ready = 1'b1;
    settle();
    check_eq("st_done", bus.Done, 1'b1);
    check_eq("st_fw_en", bus.FW_En, 1'b0);
    tick();
    settle();
    check_eq("st_post_valid", bus.Store_Valid, 1'b0);
    check_eq("st_post_ready", bus.Instr_Ready, 1'b1);
    bus.Store_Ready = 1'b0;
    tick();

    // Reserved kind
    push_exp(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    bus.Instr_Valid = 1'b1;
    bus.Instr_Kind  = 2'b11;
    tick();
    bus.Instr_Valid = 1'b0;
    settle();
    check_eq("err_done", bus.Done, 1'b1);
    check_eq("err_err", bus.Err, 1'b1);
    check_eq("err_fw_en", bus.FW_En, 1'b0);
    tick();
    settle();
    check_eq("err_post_ready", bus.Instr_Ready, 1'b1);
    check_eq("err_post_err", bus.Err, 1'b0);

    // Stray handshakes in IDLE do nothing
    bus.Load_Valid  = 1'b1;
    bus.Store_Ready = 1'b1;
    settle();
    check_eq("stray_fw_en", bus.FW_En, 1'b0);
    check_eq("stray_done", bus.Done, 1'b0);
    tick();
    bus.Load_Valid  = 1'b0;
    bus.Store_Ready = 1'b0;

    // Clear in IDLE, accumulate, then clear coincident with write-back
    bus.Clr_Status = 1'b1;
    tick();
    bus.Clr_Status = 1'b0;
    settle();
    check_eq("clr_idle_sticky", bus.Status_Sticky, 6'd0);
    tick();
    run_alu(4'd5, 5'd9, 5'd10, 5'd9, 6'b100000, 1'b0, 6'b100000);
    run_alu(4'd1, 5'd2, 5'd3, 5'd3, 6'b000001, 1'b1, 6'b000001);

    // Reset while LOAD_WAIT sees Load_Valid
    bus.Instr_Valid = 1'b1;
    bus.Instr_Kind  = 2'b01;
    bus.Instr_D     = 5'd3;
    tick();
    bus.Instr_Valid = 1'b0;
    settle();
    check_eq("rl_wait_ready", bus.Load_Ready, 1'b1);
    tick();
    Reset          = 1'b1;
    bus.Load_Valid = 1'b1;
    settle();
    check_eq("rl_fw_en", bus.FW_En, 1'b0);
    check_eq("rl_done", bus.Done, 1'b0);
    check_eq("rl_load_ready", bus.Load_Ready, 1'b0);
    check_eq("rl_busy", bus.Busy, 1'b0);
    tick();
    Reset          = 1'b0;
    bus.Load_Valid = 1'b0;
    settle();
    check_eq("rl_idle_ready", bus.Instr_Ready, 1'b1);
    check_eq("rl_sticky", bus.Status_Sticky, 6'd0);
    check_eq("rl_fw_addr", bus.FW_Addr, 5'd0);
    check_eq("rl_store_data", bus.Store_Data, 64'd0);
    bus.Load_Valid = 1'b1;
    settle();
    check_eq("rl_idle_fw_en", bus.FW_En, 1'b0);
    tick();
    bus.Load_Valid = 1'b0;
    tick();

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
